// File: rtl/blit_pkg.sv
// Shared definitions for the sprite blitter: FSM encodings, default widths
// and the transparent-word constant.
package blit_pkg;

    localparam int DEF_ADDR_WIDTH     = 14;
    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_ROM_ADDR_WIDTH = 8;
    localparam int DEF_ROM_LATENCY    = 2;
    localparam int DEF_WORDS_PER_ROW  = 16;
    localparam int DEF_FB_STRIDE      = 40;

    localparam logic [15:0] TRANSPARENT_WORD = 16'h0000;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic logic state_is_busy(input state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/blit_fifo.sv
// Small synchronous FIFO holding ROM words waiting for a free SPRAM slot,
// plus the checker that flags a push into a full FIFO.
module blit_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign empty     = (count_r == {CNT_W{1'b0}});
    assign full      = (count_r == CNT_W'(DEPTH));
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    // A simultaneous pop frees the slot being written, so push-on-full is legal then.
    assign do_push_s = push && (!full || do_pop_s);

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

module blit_fifo_chk (
    input logic clk,
    input logic reset_n,
    input logic push,
    input logic pop,
    input logic full
);

    overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && full && !pop));

endmodule

// File: rtl/sprite_blit_ctrl.sv
// Copies one 256-word sprite from ROM into the framebuffer SPRAM, sharing
// the SPRAM port with scanout reads which always win arbitration.
module sprite_blit_ctrl
    import blit_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ROM_ADDR_WIDTH = DEF_ROM_ADDR_WIDTH,
    parameter int ROM_LATENCY    = DEF_ROM_LATENCY,
    parameter int WORDS_PER_ROW  = DEF_WORDS_PER_ROW,
    parameter int FB_STRIDE      = DEF_FB_STRIDE
)(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     dest_base,
    input  logic                      trans_en,
    output logic                      busy,
    output logic                      done,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]     rom_dout,
    input  logic                      disp_req,
    input  logic [ADDR_WIDTH-1:0]     disp_addr,
    output logic                      disp_rvalid,
    output logic [DATA_WIDTH-1:0]     disp_rdata,
    output logic                      spram_wr_en,
    output logic [ADDR_WIDTH-1:0]     spram_addr,
    output logic [DATA_WIDTH-1:0]     spram_din,
    input  logic [DATA_WIDTH-1:0]     spram_dout
);

    localparam int FIFO_DEPTH = ROM_LATENCY + 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int COL_W      = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

    state_t                    state_r;
    state_t                    state_next_s;
    logic                      busy_r;
    logic                      done_r;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_r;
    logic [ROM_LATENCY-1:0]    vld_r;
    logic                      trans_en_r;
    logic [COL_W-1:0]          col_r;
    logic [ADDR_WIDTH-1:0]     row_base_r;
    logic                      disp_rvalid_r;

    logic [CNT_W-1:0]          inflight_s;
    logic [CNT_W:0]            occ_s;
    logic                      issue_s;
    logic                      last_issue_s;
    logic                      push_s;
    logic                      pop_s;
    logic                      skip_s;
    logic [ADDR_WIDTH-1:0]     blit_addr_s;

    logic [DATA_WIDTH-1:0]     fifo_dout_s;
    logic [CNT_W-1:0]          fifo_count_s;
    logic                      fifo_empty_s;
    logic                      fifo_full_s;

    function automatic logic word_is_clear(input logic [DATA_WIDTH-1:0] w);
        return (w == DATA_WIDTH'(TRANSPARENT_WORD));
    endfunction

    blit_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .pop     (pop_s),
        .din     (rom_dout),
        .dout    (fifo_dout_s),
        .count   (fifo_count_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s)
    );

    blit_fifo_chk u_fifo_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .pop     (pop_s),
        .full    (fifo_full_s)
    );

    // Count ROM reads still in the latency pipe.
    always_comb begin
        inflight_s = {CNT_W{1'b0}};
        for (int i = 0; i < ROM_LATENCY; i++) begin
            inflight_s = inflight_s + CNT_W'(vld_r[i]);
        end
    end

    // Issue only while every outstanding word is guaranteed a FIFO slot.
    always_comb begin
        occ_s        = {1'b0, fifo_count_s} + {1'b0, inflight_s};
        issue_s      = (state_r == ST_RUN) && (occ_s < (CNT_W + 1)'(FIFO_DEPTH));
        last_issue_s = issue_s && (rom_addr_r == {ROM_ADDR_WIDTH{1'b1}});
        push_s       = vld_r[ROM_LATENCY-1];
        blit_addr_s  = row_base_r + ADDR_WIDTH'(col_r);
        skip_s       = trans_en_r && word_is_clear(fifo_dout_s);
    end

    // SPRAM port arbitration: display first, then the FIFO head.
    always_comb begin
        pop_s       = 1'b0;
        spram_wr_en = 1'b0;
        spram_addr  = disp_addr;
        spram_din   = fifo_dout_s;
        if (disp_req) begin
            pop_s = 1'b0;
        end else if (!fifo_empty_s) begin
            pop_s       = 1'b1;
            spram_addr  = blit_addr_s;
            spram_wr_en = !skip_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_issue_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((inflight_s == {CNT_W{1'b0}}) && fifo_empty_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state and its registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= state_is_busy(state_next_s);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // ROM address counter and the valid tags for returning data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr_r <= {ROM_ADDR_WIDTH{1'b0}};
            vld_r      <= {ROM_LATENCY{1'b0}};
        end else begin
            vld_r <= (vld_r << 1) | ROM_LATENCY'(issue_s);
            if (issue_s) begin
                rom_addr_r <= rom_addr_r + ROM_ADDR_WIDTH'(1);
            end
        end
    end

    // Destination walk: column within the sprite row plus running row base.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trans_en_r <= 1'b0;
            col_r      <= {COL_W{1'b0}};
            row_base_r <= {ADDR_WIDTH{1'b0}};
        end else if ((state_r == ST_IDLE) && start) begin
            trans_en_r <= trans_en;
            col_r      <= {COL_W{1'b0}};
            row_base_r <= dest_base;
        end else if (pop_s) begin
            if (col_r == COL_W'(WORDS_PER_ROW - 1)) begin
                col_r      <= {COL_W{1'b0}};
                row_base_r <= row_base_r + ADDR_WIDTH'(FB_STRIDE);
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    // Display read valid follows the request by the SPRAM latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_rvalid_r <= 1'b0;
        end else begin
            disp_rvalid_r <= disp_req;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign rom_addr    = rom_addr_r;
    assign disp_rvalid = disp_rvalid_r;
    assign disp_rdata  = spram_dout;

endmodule

// File: tb/tb_sprite_blit_ctrl.sv
// Directed bench for sprite_blit_ctrl with ROM/SPRAM models and queue-based
// scoreboards for blit writes and display reads.
module tb_sprite_blit_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [13:0] dest_base;
    logic        trans_en;
    logic        busy;
    logic        done;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        disp_req;
    logic [13:0] disp_addr;
    logic        disp_rvalid;
    logic [15:0] disp_rdata;
    logic        spram_wr_en;
    logic [13:0] spram_addr;
    logic [15:0] spram_din;
    logic [15:0] spram_dout;

    typedef struct packed { logic [13:0] a; logic [15:0] d; } wr_t;
    typedef struct packed { logic v; logic [15:0] d; } rd_t;

    wr_t         wr_q [$];
    rd_t         rd_q [$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          done_cnt    = 0;
    logic        mon_en      = 1'b0;
    logic        rom_transp  = 1'b0;
    logic        fill_go     = 1'b0;
    logic [15:0] rom_r1, rom_r2, fb_q;
    logic [15:0] fb [16384];

    always #5 clk = ~clk;

    sprite_blit_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dest_base   (dest_base),
        .trans_en    (trans_en),
        .busy        (busy),
        .done        (done),
        .rom_addr    (rom_addr),
        .rom_dout    (rom_dout),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .spram_wr_en (spram_wr_en),
        .spram_addr  (spram_addr),
        .spram_din   (spram_din),
        .spram_dout  (spram_dout)
    );

    function automatic logic [15:0] rom_word(input logic [7:0] k, input logic t);
        return (t && !k[0]) ? 16'h0000 : ({8'h00, k} + 16'd1);
    endfunction

    function automatic logic [15:0] disp_word(input logic [13:0] a);
        return {2'b00, a} ^ 16'h5A5A;
    endfunction

    // Two-register synchronous sprite ROM.
    always @(posedge clk) begin
        rom_r1 <= rom_word(rom_addr, rom_transp);
        rom_r2 <= rom_r1;
    end
    assign rom_dout = rom_r2;

    // Framebuffer SPRAM, with a bulk preload used between tests.
    always @(posedge clk) begin
        if (fill_go) begin
            for (int a = 0; a < 16384; a++) begin
                fb[a] <= (a >= 8000) ? disp_word(14'(a)) : 16'hFFFF;
            end
        end else if (spram_wr_en) begin
            fb[spram_addr] <= spram_din;
        end
        fb_q <= fb[spram_addr];
    end
    assign spram_dout = fb_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard and per-cycle port rules, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (spram_wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 32'(spram_addr), 32'hFFFFFFFF);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", 32'(spram_addr), 32'(w.a));
                    chk("wr_data", 32'(spram_din), 32'(w.d));
                end
            end
            if (disp_req) begin
                chk("disp_blocks_write", 32'(spram_wr_en), 32'd0);
                chk("disp_addr_route", 32'(spram_addr), 32'(disp_addr));
            end
            chk("addr_known", 32'($isunknown(spram_addr)), 32'd0);
            if (done) done_cnt++;
        end
    end

    task automatic do_fill();
        fill_go = 1'b1;
        @(posedge clk); #1;
        fill_go = 1'b0;
    endtask

    task automatic run_copy(input logic [13:0] base, input logic transp,
                            input int dlo, input int dhi, input int busy_cyc,
                            input int rst_cyc, input int exp_done);
        int   done_at;
        logic stop;
        rd_t  r;
        rom_transp = transp;
        wr_q.delete();
        for (int k = 0; k < 256; k++) begin
            if (!(transp && (k % 2 == 0))) begin
                wr_q.push_back('{a: base + 14'((k / 16) * 40 + (k % 16)),
                                 d: rom_word(8'(k), transp)});
            end
        end
        rd_q.delete();
        rd_q.push_back('{v: 1'b0, d: 16'h0000});
        done_cnt  = 0;
        done_at   = -1;
        stop      = 1'b0;
        dest_base = base;
        trans_en  = transp;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        trans_en  = !transp;
        dest_base = base ^ 14'h2AAA;
        for (int c = 0; c <= 600 && !stop; c++) begin
            r = rd_q.pop_front();
            chk("disp_rvalid", 32'(disp_rvalid), 32'(r.v));
            if (r.v) chk("disp_rdata", 32'(disp_rdata), 32'(r.d));
            if (c == 0) chk("busy_after_start", 32'(busy), 32'd1);
            if (done) begin
                done_at = c;
                stop    = 1'b1;
            end else if (c == rst_cyc) begin
                reset_n = 1'b0;
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_wr_en", 32'(spram_wr_en), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                wr_q.delete();
                stop = 1'b1;
            end else begin
                start     = (c == busy_cyc);
                disp_req  = (c >= dlo) && (c <= dhi);
                disp_addr = 14'(8000 + c);
                rd_q.push_back('{v: disp_req, d: disp_word(disp_addr)});
                @(posedge clk); #1;
            end
        end
        start    = 1'b0;
        disp_req = 1'b0;
        if (rst_cyc >= 0) begin
            chk("no_done_before_reset", 32'(done_cnt), 32'd0);
            repeat (2) @(posedge clk);
            #1;
            reset_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            chk("idle_after_reset", 32'(busy), 32'd0);
        end else begin
            chk("done_cycle", 32'(done_at), 32'(exp_done));
            repeat (10) @(posedge clk);
            #1;
            chk("done_once", 32'(done_cnt), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("writes_drained", 32'(wr_q.size()), 32'd0);
        end
    endtask

    task automatic check_image(input logic [13:0] base, input logic transp);
        logic [13:0] a;
        for (int k = 0; k < 256; k++) begin
            a = base + 14'((k / 16) * 40 + (k % 16));
            chk("image", 32'(fb[a]),
                32'((transp && (k % 2 == 0)) ? 16'hFFFF : 16'(k + 1)));
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        dest_base = 14'd0;
        trans_en  = 1'b0;
        disp_req  = 1'b0;
        disp_addr = 14'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        chk("reset_wr_en", 32'(spram_wr_en), 32'd0);
        chk("reset_rvalid", 32'(disp_rvalid), 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(posedge clk); #1;

        // Basic unstalled copy.
        do_fill();
        run_copy(14'd0, 1'b0, -1, -1, -1, -1, 260);
        check_image(14'd0, 1'b0);

        // Display holds the port for 20 cycles mid-copy.
        do_fill();
        run_copy(14'd0, 1'b0, 10, 29, -1, -1, 280);
        check_image(14'd0, 1'b0);

        // Transparent words leave the preload untouched.
        do_fill();
        run_copy(14'd0, 1'b1, -1, -1, -1, -1, 260);
        check_image(14'd0, 1'b1);

        // Destination wraps past the top of the framebuffer.
        do_fill();
        run_copy(14'd16380, 1'b0, -1, -1, -1, -1, 260);
        chk("wrap_word4", 32'(fb[0]), 32'd5);
        chk("wrap_word16", 32'(fb[36]), 32'd17);
        check_image(14'd16380, 1'b0);

        // Reset mid-copy, then a fresh full copy.
        do_fill();
        run_copy(14'd0, 1'b0, -1, -1, -1, 100, 0);
        do_fill();
        run_copy(14'd0, 1'b0, -1, -1, -1, -1, 260);
        check_image(14'd0, 1'b0);

        // A second start while busy is ignored.
        do_fill();
        run_copy(14'd200, 1'b0, -1, -1, 50, -1, 260);
        check_image(14'd200, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sprite_blit_ctrl.md
Name: sprite_blit_ctrl

Overview:
- Sequences one sprite copy from a 256-word sprite ROM into the single-port framebuffer SPRAM, at a programmable destination with a fixed row stride.
- Shares the SPRAM port with the display scanout reader. Display reads always have priority; blit writes stall behind them.
- Sits between the sprite ROMs, the framebuffer SPRAM and the scanout/game-logic front end.

Parameters:
- ADDR_WIDTH, 14, SPRAM word address width
- DATA_WIDTH, 16, ROM/SPRAM word width
- ROM_ADDR_WIDTH, 8, sprite ROM address width (256 words per sprite)
- ROM_LATENCY, 2, cycles from rom_addr to valid rom_dout (matches the two-register sync ROM)
- WORDS_PER_ROW, 16, sprite words per sprite row (64 px at 4 bpp)
- FB_STRIDE, 40, SPRAM words per framebuffer line

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin copy; sampled only in IDLE
- dest_base  in  ADDR_WIDTH  SPRAM address of sprite word 0; captured on accepted start
- trans_en  in  1  skip writes of word 16'h0000; captured on accepted start
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse when last write completes
- rom_addr  out  ROM_ADDR_WIDTH  sprite ROM address
- rom_dout  in  DATA_WIDTH  sprite ROM data
- disp_req  in  1  display read request this cycle
- disp_addr  in  ADDR_WIDTH  display read address
- disp_rvalid  out  1  display read data valid (1 cycle after disp_req)
- disp_rdata  out  DATA_WIDTH  display read data
- spram_wr_en  out  1  SPRAM write enable
- spram_addr  out  ADDR_WIDTH  SPRAM address
- spram_din  out  DATA_WIDTH  SPRAM write data
- spram_dout  in  DATA_WIDTH  SPRAM read data (1-cycle latency)

Behaviour:
- Reset (async, any state): IDLE. busy=0, done=0, rom_addr=0, spram_wr_en=0, disp_rvalid=0, in-flight tags and FIFO cleared. An in-progress copy is abandoned; there is no partial-completion pulse.
- FSM: IDLE -> RUN on start; RUN -> DRAIN after word 255 is issued to ROM; DRAIN -> DONE when in-flight=0 and FIFO empty; DONE -> IDLE unconditionally. done=1 only in DONE. start is ignored outside IDLE.
- Issue: in RUN, one ROM read per cycle, rom_addr increments 0..255. A ROM_LATENCY-deep valid shift register tags returning data.
- Back-pressure: returning words enter a FIFO of depth ROM_LATENCY+2. Issue is blocked when FIFO count + in-flight >= depth, so the FIFO never overflows. Overflow is an assertion failure.
- SPRAM arbitration, per cycle:
  - If disp_req=1: spram_addr=disp_addr, spram_wr_en=0, FIFO head held.
  - Else if FIFO non-empty: pop the head. Write it unless trans_en=1 and word==0; a skipped word pops with spram_wr_en=0.
  - Else: spram_wr_en=0, spram_addr=disp_addr.
- disp_rvalid is disp_req delayed 1 cycle. disp_rdata=spram_dout combinationally. Display latency is always exactly 1 and is unaffected by blits.
- Destination address for word k = dest_base + (k / WORDS_PER_ROW)*FB_STRIDE + (k % WORDS_PER_ROW), computed modulo 2^ADDR_WIDTH (wraps silently).
  - Implement with a column counter and a row-base accumulator advanced on pop, not with a multiplier.
- Unstalled copy: 256 + ROM_LATENCY + 2 cycles from start to done; each display cycle adds at most one cycle.
- Simultaneous disp_req and FIFO pop: display wins, with no loss or duplication of blit words.

Decomposition:
- Shared package blit_pkg: state enum (IDLE, RUN, DRAIN, DONE), TRANSPARENT_WORD=16'h0000, default widths.
- One natural sub-module: blit_fifo (small synchronous FIFO with count, same clk/reset_n).

Test Plan:
- Basic copy: dest_base=0, no disp_req, ROM word k=k+1 -> SPRAM[(k/16)*40+k%16]=k+1 for all 256 words; done pulses at cycle 260 after start, exactly once.
- Display priority: disp_req held high for cycles 10–29 during a copy -> disp_rvalid tracks with 1-cycle lag and correct data; no spram_wr_en in those cycles; final SPRAM image identical to the basic case; done delayed by 20 cycles.
- Transparency: trans_en=1, even words=0 -> only odd k are written; pre-filled 16'hFFFF remains at even destinations.
- Wrap: dest_base=16380 -> word 4 lands at address 0 and word 16 lands at 36; no X on spram_addr.
- Reset mid-copy: reset_n low at cycle 100 -> spram_wr_en=0 and busy=0 asynchronously. A new start after release completes a full copy normally.
- Start while busy: pulse start at cycle 50 with a different dest_base -> ignored; original copy unaffected, single done.
